// File: rtl/exec_alu_arbiter.sv
// Shares one external ALU between the execute-stage instruction op (req0) and the
// branch/jump target add (req1), with round-robin arbitration and per-requester response buffers.
module exec_alu_arbiter #(
  parameter int          WIDTH  = 16,
  parameter logic [2:0]  ADD_OP = 3'b100
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             i_valid,
  output logic             i_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_op,
  input  logic             i_cin,
  input  logic             i_inva,
  input  logic             i_invb,
  input  logic             i_sign,
  output logic             i_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WIDTH-1:0] i_rsp_out,
  output logic             i_rsp_ofl,
  output logic             i_rsp_z,

  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] b_pc,
  input  logic [WIDTH-1:0] b_off,
  input  logic             b_take,
  output logic             b_rsp_valid,
  input  logic             b_rsp_ready,
  output logic [WIDTH-1:0] b_rsp_pc,

  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  output logic             alu_cin,
  output logic             alu_inva,
  output logic             alu_invb,
  output logic             alu_sign,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_ofl,
  input  logic             alu_z,

  output logic             err
);

  logic slot_free_i;
  logic slot_free_b;
  logic req_i;
  logic req_b_alu;
  logic req_b_byp;
  logic grant_i;
  logic grant_b;
  logic last_grant;

  // Requests are masked during reset so no handshake completes in a reset cycle.
  always_comb begin
    slot_free_i = !i_rsp_valid || i_rsp_ready;
    slot_free_b = !b_rsp_valid || b_rsp_ready;
    req_i       = !rst && i_valid && slot_free_i;
    req_b_alu   = !rst && b_valid && b_take && slot_free_b;
    req_b_byp   = !rst && b_valid && !b_take && slot_free_b;
  end

  // last_grant holds the index of the requester that last won the ALU.
  always_comb begin
    grant_i = req_i && (!req_b_alu || last_grant);
    grant_b = req_b_alu && (!req_i || !last_grant);
    i_ready = grant_i;
    b_ready = grant_b || req_b_byp;
  end

  always_comb begin
    alu_a    = i_a;
    alu_b    = i_b;
    alu_op   = i_op;
    alu_cin  = i_cin;
    alu_inva = i_inva;
    alu_invb = i_invb;
    alu_sign = i_sign;
    if (grant_b) begin
      alu_a    = b_pc;
      alu_b    = b_off;
      alu_op   = ADD_OP;
      alu_cin  = 1'b0;
      alu_inva = 1'b0;
      alu_invb = 1'b0;
      alu_sign = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (grant_i) begin
      last_grant <= 1'b0;
    end else if (grant_b) begin
      last_grant <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_rsp_valid <= 1'b0;
      i_rsp_out   <= '0;
      i_rsp_ofl   <= 1'b0;
      i_rsp_z     <= 1'b0;
    end else if (grant_i) begin
      i_rsp_valid <= 1'b1;
      i_rsp_out   <= alu_out;
      i_rsp_ofl   <= alu_ofl;
      i_rsp_z     <= alu_z;
    end else if (i_rsp_ready) begin
      i_rsp_valid <= 1'b0;
    end
  end

  // A taken branch captures the wrapped ALU sum; a not-taken branch passes the old PC through.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_rsp_valid <= 1'b0;
      b_rsp_pc    <= '0;
      err         <= 1'b0;
    end else if (grant_b) begin
      b_rsp_valid <= 1'b1;
      b_rsp_pc    <= alu_out;
      if (alu_ofl) begin
        err <= 1'b1;
      end
    end else if (req_b_byp) begin
      b_rsp_valid <= 1'b1;
      b_rsp_pc    <= b_pc;
    end else if (b_rsp_ready) begin
      b_rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exec_alu_arbiter.sv
// Directed, table-driven bench for exec_alu_arbiter with a small behavioural model of the shared ALU.
module tb_exec_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_ready;
  logic [15:0] i_a, i_b;
  logic [2:0]  i_op;
  logic        i_cin, i_inva, i_invb, i_sign;
  logic        i_rsp_valid, i_rsp_ready;
  logic [15:0] i_rsp_out;
  logic        i_rsp_ofl, i_rsp_z;
  logic        b_valid, b_ready;
  logic [15:0] b_pc, b_off;
  logic        b_take;
  logic        b_rsp_valid, b_rsp_ready;
  logic [15:0] b_rsp_pc;
  logic [15:0] alu_a, alu_b;
  logic [2:0]  alu_op;
  logic        alu_cin, alu_inva, alu_invb, alu_sign;
  logic [15:0] alu_out;
  logic        alu_ofl, alu_z;
  logic        err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  exec_alu_arbiter #(.WIDTH(16), .ADD_OP(3'b100)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready), .i_a(i_a), .i_b(i_b), .i_op(i_op),
    .i_cin(i_cin), .i_inva(i_inva), .i_invb(i_invb), .i_sign(i_sign),
    .i_rsp_valid(i_rsp_valid), .i_rsp_ready(i_rsp_ready), .i_rsp_out(i_rsp_out),
    .i_rsp_ofl(i_rsp_ofl), .i_rsp_z(i_rsp_z),
    .b_valid(b_valid), .b_ready(b_ready), .b_pc(b_pc), .b_off(b_off), .b_take(b_take),
    .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready), .b_rsp_pc(b_rsp_pc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_inva(alu_inva), .alu_invb(alu_invb), .alu_sign(alu_sign),
    .alu_out(alu_out), .alu_ofl(alu_ofl), .alu_z(alu_z),
    .err(err)
  );

  // Shared ALU model: 100 add (signed or carry overflow), 000 and, 001 or, 010 xor, else pass A.
  logic [15:0] m_a, m_b;
  logic [16:0] m_sum;
  always_comb begin
    m_a     = alu_inva ? ~alu_a : alu_a;
    m_b     = alu_invb ? ~alu_b : alu_b;
    m_sum   = {1'b0, m_a} + {1'b0, m_b} + {16'd0, alu_cin};
    alu_out = m_a;
    alu_ofl = 1'b0;
    case (alu_op)
      3'b100: begin
        alu_out = m_sum[15:0];
        alu_ofl = alu_sign ? ((m_a[15] == m_b[15]) && (m_sum[15] != m_a[15])) : m_sum[16];
      end
      3'b000: alu_out = m_a & m_b;
      3'b001: alu_out = m_a | m_b;
      3'b010: alu_out = m_a ^ m_b;
      default: alu_out = m_a;
    endcase
    alu_z = (alu_out == 16'd0);
  end

  typedef struct {
    logic        iv;
    logic [15:0] ia, ib;
    logic [2:0]  iop;
    logic        icin, iinva, iinvb, isign, irr;
    logic        bv;
    logic [15:0] bpc, boff;
    logic        btake, brr;
    logic        exp_ir, exp_br, exp_irv;
    logic [15:0] exp_iout;
    logic        exp_iofl, exp_iz, exp_brv;
    logic [15:0] exp_bpc;
    logic        exp_err;
  } vec_t;

  vec_t vecs [15];

  task automatic applyStimulus(input vec_t v);
    i_valid = v.iv;  i_a = v.ia;  i_b = v.ib;  i_op = v.iop;
    i_cin = v.icin;  i_inva = v.iinva;  i_invb = v.iinvb;  i_sign = v.isign;
    i_rsp_ready = v.irr;
    b_valid = v.bv;  b_pc = v.bpc;  b_off = v.boff;  b_take = v.btake;
    b_rsp_ready = v.brr;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    // Fields: iv ia ib iop cin inva invb sign irr | bv bpc boff take brr |
    //         exp: i_ready b_ready i_rsp_valid i_rsp_out ofl z b_rsp_valid b_rsp_pc err
    vecs[0]  = '{1'b1, 16'h0005, 16'h0003, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1,
                 1'b1, 1'b0, 1'b1, 16'h0008, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[1]  = '{1'b1, 16'h00F0, 16'h0F0F, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1,
                 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0};
    vecs[2]  = '{1'b1, 16'h0001, 16'h0001, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                 1'b1, 16'h0100, 16'hFFFE, 1'b1, 1'b1,
                 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h00FE, 1'b0};
    vecs[3]  = '{1'b1, 16'h0001, 16'h0001, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                 1'b1, 16'h0100, 16'hFFFE, 1'b1, 1'b1,
                 1'b1, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 16'h00FE, 1'b0};
    vecs[4]  = '{1'b1, 16'h0001, 16'h0001, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                 1'b1, 16'h1000, 16'h0010, 1'b1, 1'b1,
                 1'b0, 1'b1, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1, 16'h1010, 1'b0};
    vecs[5]  = '{1'b1, 16'h0007, 16'h0009, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                 1'b1, 16'h0200, 16'h0000, 1'b0, 1'b1,
                 1'b1, 1'b1, 1'b1, 16'h0010, 1'b0, 1'b0, 1'b1, 16'h0200, 1'b0};
    vecs[6]  = '{1'b1, 16'h0001, 16'h0001, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                 1'b1, 16'h0002, 16'h0003, 1'b1, 1'b1,
                 1'b0, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b1, 16'h0005, 1'b0};
    vecs[7]  = '{1'b1, 16'h0003, 16'h0004, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                 1'b1, 16'h0010, 16'h0001, 1'b1, 1'b1,
                 1'b1, 1'b0, 1'b1, 16'h0007, 1'b0, 1'b0, 1'b0, 16'h0005, 1'b0};
    vecs[8]  = '{1'b1, 16'h0003, 16'h0004, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                 1'b1, 16'h0020, 16'h0002, 1'b1, 1'b1,
                 1'b0, 1'b1, 1'b1, 16'h0007, 1'b0, 1'b0, 1'b1, 16'h0022, 1'b0};
    vecs[9]  = '{1'b1, 16'h0003, 16'h0004, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                 1'b1, 16'h0030, 16'h0003, 1'b1, 1'b1,
                 1'b0, 1'b1, 1'b1, 16'h0007, 1'b0, 1'b0, 1'b1, 16'h0033, 1'b0};
    vecs[10] = '{1'b1, 16'hFFFF, 16'h0001, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                 1'b1, 16'h0040, 16'h0004, 1'b1, 1'b1,
                 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0033, 1'b0};
    vecs[11] = '{1'b0, 16'h0000, 16'h0000, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                 1'b1, 16'h7FFF, 16'h0001, 1'b1, 1'b1,
                 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h8000, 1'b1};
    vecs[12] = '{1'b0, 16'h0000, 16'h0000, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                 1'b1, 16'h0100, 16'h0004, 1'b1, 1'b1,
                 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0104, 1'b1};
    vecs[13] = '{1'b1, 16'h0005, 16'h0003, 3'b100, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1,
                 1'b1, 16'h0300, 16'h0000, 1'b0, 1'b1,
                 1'b1, 1'b1, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b1, 16'h0300, 1'b1};
    vecs[14] = '{1'b0, 16'h0000, 16'h0000, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                 1'b1, 16'h0400, 16'h0000, 1'b0, 1'b0,
                 1'b0, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b1, 16'h0300, 1'b1};

    // Power-on reset with requests pending: nothing may be accepted.
    rst = 1'b1;
    applyStimulus(vecs[3]);
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("reset i_ready", {31'd0, i_ready}, 32'd0);
    checkOutput("reset b_ready", {31'd0, b_ready}, 32'd0);
    checkOutput("reset i_rsp_valid", {31'd0, i_rsp_valid}, 32'd0);
    checkOutput("reset b_rsp_valid", {31'd0, b_rsp_valid}, 32'd0);
    checkOutput("reset err", {31'd0, err}, 32'd0);
    checkOutput("reset i_rsp_out", {16'd0, i_rsp_out}, 32'd0);

    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 15; k++) begin
      applyStimulus(vecs[k]);
      #1;
      checkOutput($sformatf("row%0d i_ready", k), {31'd0, i_ready}, {31'd0, vecs[k].exp_ir});
      checkOutput($sformatf("row%0d b_ready", k), {31'd0, b_ready}, {31'd0, vecs[k].exp_br});
      @(posedge clk);
      #1;
      checkOutput($sformatf("row%0d i_rsp_valid", k), {31'd0, i_rsp_valid}, {31'd0, vecs[k].exp_irv});
      checkOutput($sformatf("row%0d i_rsp_out", k), {16'd0, i_rsp_out}, {16'd0, vecs[k].exp_iout});
      checkOutput($sformatf("row%0d i_rsp_ofl", k), {31'd0, i_rsp_ofl}, {31'd0, vecs[k].exp_iofl});
      checkOutput($sformatf("row%0d i_rsp_z", k), {31'd0, i_rsp_z}, {31'd0, vecs[k].exp_iz});
      checkOutput($sformatf("row%0d b_rsp_valid", k), {31'd0, b_rsp_valid}, {31'd0, vecs[k].exp_brv});
      checkOutput($sformatf("row%0d b_rsp_pc", k), {16'd0, b_rsp_pc}, {16'd0, vecs[k].exp_bpc});
      checkOutput($sformatf("row%0d err", k), {31'd0, err}, {31'd0, vecs[k].exp_err});
      @(negedge clk);
    end

    // Mid-operation reset: both responses pending, err set, new requests present.
    rst = 1'b1;
    applyStimulus(vecs[3]);
    #1;
    checkOutput("midrst i_ready", {31'd0, i_ready}, 32'd0);
    checkOutput("midrst b_ready", {31'd0, b_ready}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("midrst i_rsp_valid", {31'd0, i_rsp_valid}, 32'd0);
    checkOutput("midrst b_rsp_valid", {31'd0, b_rsp_valid}, 32'd0);
    checkOutput("midrst err", {31'd0, err}, 32'd0);
    checkOutput("midrst b_rsp_pc", {16'd0, b_rsp_pc}, 32'd0);
    @(negedge clk);

    // First tie after reset goes to req0.
    rst = 1'b0;
    i_valid = 1'b1; i_a = 16'h0010; i_b = 16'h0020; i_op = 3'b100;
    i_cin = 1'b0; i_inva = 1'b0; i_invb = 1'b0; i_sign = 1'b1; i_rsp_ready = 1'b1;
    b_valid = 1'b1; b_pc = 16'h0500; b_off = 16'h0010; b_take = 1'b1; b_rsp_ready = 1'b1;
    #1;
    checkOutput("post tie1 i_ready", {31'd0, i_ready}, 32'd1);
    checkOutput("post tie1 b_ready", {31'd0, b_ready}, 32'd0);
    checkOutput("post tie1 alu_a", {16'd0, alu_a}, 32'h0010);
    @(posedge clk);
    #1;
    checkOutput("post tie1 i_rsp_out", {16'd0, i_rsp_out}, 32'h0030);
    @(negedge clk);

    // Second tie goes to req1, which must drive the fixed branch-add controls.
    i_cin = 1'b1; i_inva = 1'b1; i_invb = 1'b1; i_sign = 1'b0; i_op = 3'b010;
    #1;
    checkOutput("post tie2 i_ready", {31'd0, i_ready}, 32'd0);
    checkOutput("post tie2 b_ready", {31'd0, b_ready}, 32'd1);
    checkOutput("post tie2 alu_a", {16'd0, alu_a}, 32'h0500);
    checkOutput("post tie2 alu_b", {16'd0, alu_b}, 32'h0010);
    checkOutput("post tie2 alu_op", {29'd0, alu_op}, 32'd4);
    checkOutput("post tie2 alu ctl", {28'd0, alu_cin, alu_inva, alu_invb, alu_sign}, 32'b0001);
    @(posedge clk);
    #1;
    checkOutput("post tie2 b_rsp_valid", {31'd0, b_rsp_valid}, 32'd1);
    checkOutput("post tie2 b_rsp_pc", {16'd0, b_rsp_pc}, 32'h0510);
    checkOutput("post tie2 i_rsp_valid", {31'd0, i_rsp_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exec_alu_arbiter.md
Name: exec_alu_arbiter

Overview:
- Shares one 16-bit ALU instance between two execute-stage requesters: the instruction operation (req0) and the branch/jump target add (req1).
- Round-robin arbitration with valid/ready handshakes on both requests.
- Drives the shared ALU's inputs combinationally in the grant cycle and registers its result into a per-requester response buffer.
- A not-taken branch bypasses the ALU.

Parameters:
- WIDTH, 16, datapath width of operands/results
- ADD_OP, 3'b100, ALU op code used for branch target add

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_valid  in  1  req0 instruction op request
- i_ready  out  1  req0 accepted this cycle
- i_a, i_b  in  WIDTH  req0 operands
- i_op  in  3  req0 ALU op
- i_cin, i_inva, i_invb, i_sign  in  1 each  req0 ALU controls
- i_rsp_valid  out  1  req0 result available
- i_rsp_ready  in  1  req0 consumer takes result
- i_rsp_out  out  WIDTH  req0 registered ALU out
- i_rsp_ofl, i_rsp_z  out  1 each  req0 registered ofl/Z
- b_valid  in  1  req1 branch request
- b_ready  out  1  req1 accepted this cycle
- b_pc  in  WIDTH  old PC
- b_off  in  WIDTH  sign-extended offset
- b_take  in  1  branch/jump enable
- b_rsp_valid  out  1  req1 result available
- b_rsp_ready  in  1  req1 consumer takes result
- b_rsp_pc  out  WIDTH  next PC (b_pc+b_off if taken, else b_pc)
- alu_a, alu_b  out  WIDTH  to shared ALU
- alu_op  out  3  to shared ALU
- alu_cin, alu_inva, alu_invb, alu_sign  out  1 each  to shared ALU
- alu_out  in  WIDTH  from shared ALU
- alu_ofl, alu_z  in  1 each  from shared ALU
- err  out  1  sticky: taken-branch target overflowed

Behaviour:
- Slot free per requester: slot_free_x = !x_rsp_valid | x_rsp_ready.
- Eligibility:
  - req0 eligible = i_valid & slot_free_i.
  - req1 needs the ALU = b_valid & b_take & slot_free_b.
  - req1 bypass = b_valid & !b_take & slot_free_b.
- Bypass does not use the ALU and is never blocked by req0: b_ready=1 and b_rsp_pc <= b_pc on that edge.
- Arbitration between req0 and ALU-using req1:
  - Only one contender: it is granted.
  - Both contend: grant goes to the requester not granted last. The last_grant register is updated only on ALU grants; it resets to 1, so req0 wins the first tie.
- ALU drive in the grant cycle:
  - req0 granted: alu_* = i_* fields.
  - req1 granted: alu_a=b_pc, alu_b=b_off, alu_op=ADD_OP, cin=0, inva=0, invb=0, sign=1.
  - No grant: alu_* hold the req0 fields (don't-care; must not be X).
- Readiness: i_ready = req0 granted; b_ready = req1 granted or bypass. Both are combinational and may depend on the other valid.
- Latency: accept at edge N -> x_rsp_valid=1 from N+1 with the captured result. Full throughput: 1 accept/cycle per requester when its consumer holds rsp_ready=1.
- Response buffer:
  - Holds value and valid until rsp_ready.
  - A new accept in the same cycle as rsp_ready overwrites the buffer; valid stays 1.
  - rsp_ready with no new accept clears valid.
- err: set on the edge a taken-branch add is accepted with alu_ofl=1; cleared only by rst. b_rsp_pc still carries the wrapped sum.
- Arithmetic: no width growth; results wrap mod 2^WIDTH as produced by the ALU.
- Reset (including mid-operation):
  - i_rsp_valid=0, b_rsp_valid=0, err=0, last_grant=1.
  - Result registers=0.
  - Pending responses are discarded.
  - No ready is asserted in a reset cycle.

Test Plan:
- req0 only: i_a=0x0005, i_b=0x0003, i_op=3'b100, sign=1 -> i_ready=1 at cycle 0; cycle 1: i_rsp_valid=1, i_rsp_out=0x0008, ofl=0, z=0.
- Tie: i_valid & b_valid, b_take=1, both every cycle, both rsp_ready=1 -> grants alternate req0, req1, req0…; b_pc=0x0100, b_off=0xFFFE -> b_rsp_pc=0x00FE.
- Bypass concurrency: b_take=0, b_pc=0x0200, i_valid=1 same cycle -> both ready=1; next cycle b_rsp_pc=0x0200 and the req0 result both valid; last_grant unchanged.
- Backpressure: i_rsp_ready=0 after first result -> i_ready=0 while i_valid=1; i_rsp_out holds; b requests still granted every cycle.
- Overflow: b_pc=0x7FFF, b_off=0x0001, b_take=1 -> b_rsp_pc=0x8000, err=1 stays set through later clean branches until rst.
- Reset mid-op: rst=1 with both rsp_valid=1 -> next cycle both rsp_valid=0, err=0; a first post-reset tie grants req0.
